// File: rtl/ray_sphere_closest_hit_pkg.sv
// Shared widths and state encoding for the ray/sphere closest-hit block.
package rt_pkg;

  localparam int COORD_W  = 12;
  localparam int DIR_FRAC = 10;
  localparam int T_W      = 18;
  localparam logic [T_W-1:0] T_MISS = 18'h3FFFF;

  localparam int OC_W   = 13;
  localparam int B_W    = 17;
  localparam int C_W    = 27;
  localparam int DISC_W = 35;
  localparam int ROOT_W = 17;
  localparam int RAD_W  = 34;
  localparam int REM_W  = ROOT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT_SPH,
    S_DOT,
    S_DISC,
    S_SQRT,
    S_CMP,
    S_RESULT
  } state_t;

endpackage

// File: rtl/ray_sphere_closest_hit_isqrt.sv
// Restoring bit-serial integer square root: floor(sqrt(radicand)), one root bit per cycle.
module isqrt_seq
  import rt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAD_W-1:0]  radicand,
  output logic              done,
  output logic [ROOT_W-1:0] root
);

  logic [RAD_W-1:0]  rad_r, src_rad_s, nxt_rad_s;
  logic [REM_W-1:0]  rem_r, src_rem_s, nxt_rem_s;
  logic [ROOT_W-1:0] root_r, src_root_s, nxt_root_s;
  logic [REM_W+1:0]  shifted_s, trial_s, diff_s;
  logic [4:0]        cnt_r;
  logic              busy_r, done_r;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    if (start) begin
      src_rem_s  = '0;
      src_root_s = '0;
      src_rad_s  = radicand;
    end else begin
      src_rem_s  = rem_r;
      src_root_s = root_r;
      src_rad_s  = rad_r;
    end
    shifted_s = {src_rem_s, src_rad_s[RAD_W-1 -: 2]};
    trial_s   = {1'b0, src_root_s, 2'b01};
    diff_s    = shifted_s - trial_s;
    if (shifted_s >= trial_s) begin
      nxt_rem_s  = REM_W'(diff_s);
      nxt_root_s = {src_root_s[ROOT_W-2:0], 1'b1};
    end else begin
      nxt_rem_s  = REM_W'(shifted_s);
      nxt_root_s = {src_root_s[ROOT_W-2:0], 1'b0};
    end
    nxt_rad_s = {src_rad_s[RAD_W-3:0], 2'b00};
  end

  // Iteration registers; the first step is taken on the start edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= '0;
      root_r <= '0;
      rad_r  <= '0;
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      rem_r  <= nxt_rem_s;
      root_r <= nxt_root_s;
      rad_r  <= nxt_rad_s;
      cnt_r  <= 5'd16;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      rem_r  <= nxt_rem_s;
      root_r <= nxt_root_s;
      rad_r  <= nxt_rad_s;
      cnt_r  <= cnt_r - 5'd1;
      if (cnt_r == 5'd1) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign root = root_r;

endmodule

// File: rtl/ray_sphere_closest_hit.sv
// Closest-hit search of one ray against a streamed sphere scene.
module ray_sphere_closest_hit
  import rt_pkg::*;
#(
  parameter int TMIN = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ray_valid,
  output logic                      ray_ready,
  input  logic signed [COORD_W-1:0] ray_ox,
  input  logic signed [COORD_W-1:0] ray_oy,
  input  logic signed [COORD_W-1:0] ray_oz,
  input  logic signed [COORD_W-1:0] ray_dx,
  input  logic signed [COORD_W-1:0] ray_dy,
  input  logic signed [COORD_W-1:0] ray_dz,
  output logic                      scene_start,
  input  logic                      sph_valid,
  output logic                      sph_ready,
  input  logic [7:0]                sph_idx,
  input  logic                      sph_last,
  input  logic                      sph_done,
  input  logic signed [COORD_W-1:0] sph_cx,
  input  logic signed [COORD_W-1:0] sph_cy,
  input  logic signed [COORD_W-1:0] sph_cz,
  input  logic signed [COORD_W-1:0] sph_radius,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_hit,
  output logic [7:0]                res_idx,
  output logic [T_W-1:0]            res_t
);

  localparam logic signed [T_W-1:0] TMIN_T = T_W'(TMIN);

  state_t state_r, state_nxt_s;

  logic signed [COORD_W-1:0] ox_r, oy_r, oz_r, dx_r, dy_r, dz_r;
  logic signed [COORD_W-1:0] cx_r, cy_r, cz_r, sr_r;
  logic [7:0]                sidx_r;
  logic                      last_r;
  logic signed [B_W-1:0]     b_r, b_s;
  logic signed [C_W-1:0]     c_r, c_s, dot_s;
  logic signed [OC_W-1:0]    ocx_s, ocy_s, ocz_s;
  logic signed [DISC_W-1:0]  disc_s;
  logic signed [T_W-1:0]     tn_s, tf_s, root_ext_s;
  logic [ROOT_W-1:0]         root_s;
  logic                      sqrt_start_s, sqrt_done_s;
  logic                      cand_hit_s;
  logic [T_W-1:0]            cand_t_s;

  logic [T_W-1:0] best_t_r, best_t_nxt_s;
  logic [7:0]     best_idx_r, best_idx_nxt_s;
  logic           best_hit_r, best_hit_nxt_s;

  logic           ray_ready_r, scene_start_r, sph_ready_r, res_valid_r;
  logic           res_hit_r;
  logic [7:0]     res_idx_r;
  logic [T_W-1:0] res_t_r;

  // Geometry arithmetic: b = floor(oc.D / 2^DIR_FRAC), c = |oc|^2 - r^2, disc = b^2 - c.
  always_comb begin
    ocx_s  = OC_W'(cx_r) - OC_W'(ox_r);
    ocy_s  = OC_W'(cy_r) - OC_W'(oy_r);
    ocz_s  = OC_W'(cz_r) - OC_W'(oz_r);
    dot_s  = C_W'(ocx_s) * C_W'(dx_r) + C_W'(ocy_s) * C_W'(dy_r) + C_W'(ocz_s) * C_W'(dz_r);
    b_s    = B_W'(dot_s >>> DIR_FRAC);
    c_s    = C_W'(ocx_s) * C_W'(ocx_s) + C_W'(ocy_s) * C_W'(ocy_s)
           + C_W'(ocz_s) * C_W'(ocz_s) - C_W'(sr_r) * C_W'(sr_r);
    disc_s = DISC_W'(b_r) * DISC_W'(b_r) - DISC_W'(c_r);
  end

  isqrt_seq u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sqrt_start_s),
    .radicand (disc_s[RAD_W-1:0]),
    .done     (sqrt_done_s),
    .root     (root_s)
  );

  // Root selection: near root unless it fails the self-intersection guard.
  always_comb begin
    root_ext_s = $signed({1'b0, root_s});
    tn_s       = T_W'(b_r) - root_ext_s;
    tf_s       = T_W'(b_r) + root_ext_s;
    if (tn_s > TMIN_T) begin
      cand_hit_s = 1'b1;
      cand_t_s   = tn_s;
    end else if (tf_s > TMIN_T) begin
      cand_hit_s = 1'b1;
      cand_t_s   = tf_s;
    end else begin
      cand_hit_s = 1'b0;
      cand_t_s   = T_MISS;
    end
  end

  // Next-state and best-hit update.
  always_comb begin
    state_nxt_s    = state_r;
    best_t_nxt_s   = best_t_r;
    best_idx_nxt_s = best_idx_r;
    best_hit_nxt_s = best_hit_r;
    sqrt_start_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ray_valid && ray_ready_r) begin
          state_nxt_s    = S_KICK;
          best_t_nxt_s   = T_MISS;
          best_idx_nxt_s = 8'd0;
          best_hit_nxt_s = 1'b0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_KICK: state_nxt_s = S_WAIT_SPH;
      S_WAIT_SPH: begin
        if (sph_valid && sph_ready_r) begin
          state_nxt_s = S_DOT;
        end else if (sph_done) begin
          state_nxt_s = S_RESULT;
        end else begin
          state_nxt_s = S_WAIT_SPH;
        end
      end
      S_DOT: state_nxt_s = S_DISC;
      S_DISC: begin
        if (disc_s[DISC_W-1]) begin
          state_nxt_s = last_r ? S_RESULT : S_WAIT_SPH;
        end else begin
          sqrt_start_s = 1'b1;
          state_nxt_s  = S_SQRT;
        end
      end
      S_SQRT: begin
        if (sqrt_done_s) begin
          state_nxt_s = S_CMP;
        end else begin
          state_nxt_s = S_SQRT;
        end
      end
      S_CMP: begin
        // Strict less-than keeps the earlier sphere on a tie.
        if (cand_hit_s && (cand_t_s < best_t_r)) begin
          best_t_nxt_s   = cand_t_s;
          best_idx_nxt_s = sidx_r;
          best_hit_nxt_s = 1'b1;
        end else begin
          best_hit_nxt_s = best_hit_r;
        end
        state_nxt_s = last_r ? S_RESULT : S_WAIT_SPH;
      end
      S_RESULT: begin
        if (res_ready && res_valid_r) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESULT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, best-so-far and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      best_t_r      <= T_MISS;
      best_idx_r    <= 8'd0;
      best_hit_r    <= 1'b0;
      ray_ready_r   <= 1'b0;
      scene_start_r <= 1'b0;
      sph_ready_r   <= 1'b0;
      res_valid_r   <= 1'b0;
      res_hit_r     <= 1'b0;
      res_idx_r     <= 8'd0;
      res_t_r       <= T_MISS;
    end else begin
      state_r       <= state_nxt_s;
      best_t_r      <= best_t_nxt_s;
      best_idx_r    <= best_idx_nxt_s;
      best_hit_r    <= best_hit_nxt_s;
      ray_ready_r   <= (state_nxt_s == S_IDLE);
      scene_start_r <= (state_nxt_s == S_KICK);
      sph_ready_r   <= (state_nxt_s == S_WAIT_SPH);
      res_valid_r   <= (state_nxt_s == S_RESULT);
      if (state_nxt_s == S_RESULT) begin
        res_hit_r <= best_hit_nxt_s;
        res_idx_r <= best_idx_nxt_s;
        res_t_r   <= best_t_nxt_s;
      end
    end
  end

  // Ray, sphere and dot-stage operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_r <= '0; oy_r <= '0; oz_r <= '0;
      dx_r <= '0; dy_r <= '0; dz_r <= '0;
      cx_r <= '0; cy_r <= '0; cz_r <= '0; sr_r <= '0;
      sidx_r <= 8'd0;
      last_r <= 1'b0;
      b_r    <= '0;
      c_r    <= '0;
    end else begin
      if (state_r == S_IDLE && ray_valid && ray_ready_r) begin
        ox_r <= ray_ox; oy_r <= ray_oy; oz_r <= ray_oz;
        dx_r <= ray_dx; dy_r <= ray_dy; dz_r <= ray_dz;
      end
      if (state_r == S_WAIT_SPH && sph_valid && sph_ready_r) begin
        cx_r   <= sph_cx;
        cy_r   <= sph_cy;
        cz_r   <= sph_cz;
        sr_r   <= sph_radius;
        sidx_r <= sph_idx;
        last_r <= sph_last;
      end
      if (state_r == S_DOT) begin
        b_r <= b_s;
        c_r <= c_s;
      end
    end
  end

  assign ray_ready   = ray_ready_r;
  assign scene_start = scene_start_r;
  assign sph_ready   = sph_ready_r;
  assign res_valid   = res_valid_r;
  assign res_hit     = res_hit_r;
  assign res_idx     = res_idx_r;
  assign res_t       = res_t_r;

endmodule

// File: tb/tb_ray_sphere_closest_hit.sv
// Directed bench for ray_sphere_closest_hit with a plain-arithmetic scene model.
module tb_ray_sphere_closest_hit;
  import rt_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ray_valid, ray_ready, scene_start;
  logic [COORD_W-1:0] ray_ox, ray_oy, ray_oz, ray_dx, ray_dy, ray_dz;
  logic sph_valid, sph_ready, sph_last, sph_done;
  logic [7:0] sph_idx;
  logic [COORD_W-1:0] sph_cx, sph_cy, sph_cz, sph_radius;
  logic res_valid, res_ready, res_hit;
  logic [7:0] res_idx;
  logic [17:0] res_t;

  ray_sphere_closest_hit dut (
    .clk(clk), .rst_n(rst_n),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_ox(ray_ox), .ray_oy(ray_oy), .ray_oz(ray_oz),
    .ray_dx(ray_dx), .ray_dy(ray_dy), .ray_dz(ray_dz),
    .scene_start(scene_start),
    .sph_valid(sph_valid), .sph_ready(sph_ready), .sph_idx(sph_idx),
    .sph_last(sph_last), .sph_done(sph_done),
    .sph_cx(sph_cx), .sph_cy(sph_cy), .sph_cz(sph_cz), .sph_radius(sph_radius),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_idx(res_idx), .res_t(res_t)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int q_cx[$], q_cy[$], q_cz[$], q_r[$];
  int m_ox, m_oy, m_oz, m_dx, m_dy, m_dz;
  bit exp_pending = 1'b0;
  bit e_hit;
  int e_idx;
  longint e_t;
  int results_seen = 0;
  localparam longint MISS_T = 262143;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Model of one sphere test from the geometric definition.
  function automatic void sphere_eval(input int i, output bit hit, output longint t, output bit neg);
    longint ocx, ocy, ocz, dot, b, c, disc, s, tn, tf;
    ocx = longint'(q_cx[i] - m_ox);
    ocy = longint'(q_cy[i] - m_oy);
    ocz = longint'(q_cz[i] - m_oz);
    dot = ocx * m_dx + ocy * m_dy + ocz * m_dz;
    b = dot >>> DIR_FRAC;
    c = ocx * ocx + ocy * ocy + ocz * ocz - longint'(q_r[i]) * q_r[i];
    disc = b * b - c;
    neg = (disc < 0);
    hit = 1'b0;
    t = MISS_T;
    if (!neg) begin
      s = longint'($floor($sqrt(real'(disc))));
      while (s * s > disc) s--;
      while ((s + 1) * (s + 1) <= disc) s++;
      tn = b - s;
      tf = b + s;
      if (tn > 1) begin
        hit = 1'b1; t = tn;
      end else if (tf > 1) begin
        hit = 1'b1; t = tf;
      end
    end
  endfunction

  function automatic void scene_eval(output bit hit, output int idx, output longint t);
    hit = 1'b0; idx = 0; t = MISS_T;
    for (int i = 0; i < q_cx.size(); i++) begin
      bit h, n;
      longint ti;
      sphere_eval(i, h, ti, n);
      if (h && ti < t) begin
        hit = 1'b1; idx = i; t = ti;
      end
    end
  endfunction

  task automatic clear_scene();
    q_cx.delete(); q_cy.delete(); q_cz.delete(); q_r.delete();
  endtask

  task automatic add_sph(input int cx, input int cy, input int cz, input int r);
    q_cx.push_back(cx); q_cy.push_back(cy); q_cz.push_back(cz); q_r.push_back(r);
  endtask

  task automatic set_model(input int ox, input int oy, input int oz, input int dx, input int dy, input int dz);
    m_ox = ox; m_oy = oy; m_oz = oz; m_dx = dx; m_dy = dy; m_dz = dz;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ray_ready"}, 64'(ray_ready), 64'(0));
    chk({tag, "_scene_start"}, 64'(scene_start), 64'(0));
    chk({tag, "_sph_ready"}, 64'(sph_ready), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_res_hit"}, 64'(res_hit), 64'(0));
    chk({tag, "_res_idx"}, 64'(res_idx), 64'(0));
    chk({tag, "_res_t"}, 64'(res_t), 64'(18'h3FFFF));
  endtask

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (!exp_pending) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=res_valid_1 required=no_result");
      end else begin
        chk("res_hit", 64'(res_hit), 64'(e_hit));
        chk("res_idx", 64'(res_idx), 64'(e_idx));
        chk("res_t", 64'(res_t), 64'(e_t));
        if (res_ready) begin
          exp_pending = 1'b0;
          results_seen++;
        end
      end
    end
  end

  task automatic start_ray();
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    ray_ox = COORD_W'(m_ox); ray_oy = COORD_W'(m_oy); ray_oz = COORD_W'(m_oz);
    ray_dx = COORD_W'(m_dx); ray_dy = COORD_W'(m_dy); ray_dz = COORD_W'(m_dz);
    ray_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ray_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    ray_valid = 1'b0;
    chk("ray_accept", 64'(ok), 64'(1));
    @(negedge clk);
    chk("scene_start_pulse", 64'(scene_start), 64'(1));
    chk("ray_ready_busy", 64'(ray_ready), 64'(0));
    @(negedge clk);
    chk("scene_start_single", 64'(scene_start), 64'(0));
  endtask

  task automatic send_sphere(input int i, input bit last, output int gap);
    bit ok;
    ok = 1'b0;
    gap = -1;
    @(posedge clk); #1;
    sph_idx = 8'(i);
    sph_cx = COORD_W'(q_cx[i]); sph_cy = COORD_W'(q_cy[i]); sph_cz = COORD_W'(q_cz[i]);
    sph_radius = COORD_W'(q_r[i]);
    sph_last = last;
    sph_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sph_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    sph_valid = 1'b0;
    sph_last = 1'b0;
    chk("sph_accept", 64'(ok), 64'(1));
    if (ok && !last) begin
      gap = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (sph_ready) break;
        @(posedge clk);
        gap++;
      end
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    sph_done = 1'b1;
    @(posedge clk); #1;
    sph_done = 1'b0;
  endtask

  task automatic finish_ray(input int hold, input int seen0);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("res_valid_arrives", 64'(got), 64'(1));
    if (!got) begin
      exp_pending = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("ray_ready_in_result", 64'(ray_ready), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("result_taken", 64'(results_seen), 64'(seen0 + 1));
    chk("res_valid_drops", 64'(res_valid), 64'(0));
    chk("ray_ready_back", 64'(ray_ready), 64'(1));
  endtask

  task automatic run_ray(input int ox, input int oy, input int oz, input int dx, input int dy,
                         input int dz, input bit use_done, input int hold, output int gap0);
    int seen0, g, n;
    bit h, neg;
    longint ti;
    set_model(ox, oy, oz, dx, dy, dz);
    scene_eval(e_hit, e_idx, e_t);
    exp_pending = 1'b1;
    seen0 = results_seen;
    gap0 = -1;
    n = q_cx.size();
    start_ray();
    for (int i = 0; i < n; i++) begin
      bit last;
      last = !use_done && (i == n - 1);
      send_sphere(i, last, g);
      if (!last) begin
        sphere_eval(i, h, ti, neg);
        chk("sph_ready_gap", 64'(g), neg ? 64'(2) : 64'(20));
        if (i == 0) gap0 = g;
      end
    end
    if (use_done) pulse_done();
    finish_ray(hold, seen0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mh, mn;
    int mi, gap;
    longint mt;
    rst_n = 1'b0;
    ray_valid = 1'b0; sph_valid = 1'b0; sph_last = 1'b0; sph_done = 1'b0; res_ready = 1'b0;
    ray_ox = '0; ray_oy = '0; ray_oz = '0; ray_dx = '0; ray_dy = '0; ray_dz = '0;
    sph_idx = 8'd0; sph_cx = '0; sph_cy = '0; sph_cz = '0; sph_radius = '0;
    #12;
    check_reset_outputs("por");
    #10 rst_n = 1'b1;
    #1 chk("ray_ready_first_cycle", 64'(ray_ready), 64'(0));
    @(negedge clk);
    chk("ray_ready_idle", 64'(ray_ready), 64'(1));

    // Hand-computed pins on the model itself.
    clear_scene(); add_sph(0, 0, 100, 20); set_model(0, 0, 0, 0, 0, 1024);
    scene_eval(mh, mi, mt);
    chk("model_single_t", 64'(mt), 64'(80));
    clear_scene(); add_sph(0, 0, 200, 10); add_sph(0, 0, 100, 10);
    scene_eval(mh, mi, mt);
    chk("model_nearest_idx", 64'(mi), 64'(1));
    chk("model_nearest_t", 64'(mt), 64'(90));
    clear_scene(); add_sph(100, 0, 100, 20);
    sphere_eval(0, mh, mt, mn);
    chk("model_miss_neg", 64'(mn), 64'(1));
    clear_scene(); add_sph(0, 0, 0, 50);
    scene_eval(mh, mi, mt);
    chk("model_inside_t", 64'(mt), 64'(50));

    // Single sphere, terminated by sph_done so the re-ready gap is visible.
    clear_scene(); add_sph(0, 0, 100, 20);
    run_ray(0, 0, 0, 0, 0, 1024, 1'b1, 0, gap);
    chk("gap_hit_literal", 64'(gap), 64'(20));

    clear_scene(); add_sph(0, 0, 200, 10); add_sph(0, 0, 100, 10);
    run_ray(0, 0, 0, 0, 0, 1024, 1'b0, 0, gap);

    clear_scene(); add_sph(0, 0, 100, 10); add_sph(0, 0, 100, 10);
    run_ray(0, 0, 0, 0, 0, 1024, 1'b0, 0, gap);

    clear_scene(); add_sph(100, 0, 100, 20);
    run_ray(0, 0, 0, 0, 0, 1024, 1'b1, 0, gap);
    chk("gap_miss_literal", 64'(gap), 64'(2));

    clear_scene(); add_sph(0, 0, 0, 50);
    run_ray(0, 0, 0, 0, 0, 1024, 1'b0, 0, gap);

    clear_scene();
    run_ray(5, -7, 3, 0, 1024, 0, 1'b1, 0, gap);

    // Diagonal ray: sphere behind (roots negative), miss, then one ahead.
    clear_scene(); add_sph(-100, 0, -100, 20); add_sph(300, -200, 0, 10); add_sph(100, 0, 100, 30);
    run_ray(0, 0, 0, 724, 0, 724, 1'b0, 0, gap);

    // Backpressure on the result.
    clear_scene(); add_sph(0, 0, 100, 20);
    run_ray(0, 0, 0, 0, 0, 1024, 1'b0, 5, gap);

    // Reset in the middle of the square root: the aborted ray must yield nothing.
    clear_scene(); add_sph(0, 0, 100, 20); set_model(0, 0, 0, 0, 0, 1024);
    start_ray();
    send_sphere(0, 1'b1, gap);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_sqrt");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ray_ready_after_abort", 64'(ray_ready), 64'(0));
    clear_scene();
    run_ray(0, 0, 0, 0, 0, 1024, 1'b1, 0, gap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
